bit_balance_monitor: RTL
========================

Name: bit_balance_monitor

Overview:
- Downstream consumer of the per-byte popcount stage, which emits a registered 4-bit count (0..8) of ones per input byte.
- Accumulates signed running disparity (ones minus zeros) and total ones over a fixed window of accepted bytes.
- Reports the window result through a valid/ready handshake and flags windows whose absolute disparity exceeds a threshold.
- Used by the bit-balance check path to detect DC-unbalanced data streams.

Parameters:
- WINDOW, 16, number of accepted counts per reporting window (>=2).
- ACC_W, 10, width of the disparity and ones accumulators (disparity is two's complement).
- THRESH, 32, unsigned imbalance threshold; out_imbalance = |disparity| > THRESH.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_count is valid this cycle.
- in_ready  output  1  block can accept in_count; combinational decode of state.
- in_count  input  4  ones count of one byte; legal range 0..8.
- clear  input  1  synchronous abort of the current window.
- out_valid  output  1  window result valid.
- out_ready  input  1  downstream accepts the result.
- out_disparity  output  ACC_W  signed sum of (2*in_count - 8) over the window.
- out_ones  output  ACC_W  unsigned sum of in_count over the window.
- out_imbalance  output  1  |out_disparity| > THRESH.
- out_err  output  1  at least one in_count > 8 was seen in the window.

Behaviour:
- Reset (async, active-high): state IDLE; accumulators, byte counter, sticky err, out_valid, out_disparity, out_ones, out_imbalance and out_err all 0.
- States:
  - IDLE: no bytes accepted yet.
  - ACCUM: 1..WINDOW-1 bytes accepted.
  - REPORT: result held on outputs.
- in_ready = 1 in IDLE/ACCUM, 0 in REPORT.
- Accept = in_valid & in_ready.
- Per accepted byte:
  - c = min(in_count, 8). If in_count > 8, set sticky err.
  - ones_acc += c; disp_acc += 2*c - 8, a term in [-8, +8].
  - Byte counter increments.
- IDLE -> ACCUM on accept. ACCUM stays in ACCUM until the accept that makes the byte counter equal WINDOW.
- On the WINDOW-th accept, on the same edge:
  - Result registers load the totals, including that byte.
  - out_valid = 1; state -> REPORT.
  - Latency: result visible one cycle after the final accepted byte.
- out_imbalance and out_err are registered together with out_disparity and out_ones.
- REPORT:
  - All out_* held stable while out_valid & !out_ready.
  - On out_valid & out_ready: out_valid -> 0, accumulators, counter and err -> 0, state -> IDLE.
  - in_ready rises the cycle after the handshake; no byte is accepted in the handshake cycle.
- Arithmetic: accumulators saturate at +(2^(ACC_W-1)-1) / -(2^(ACC_W-1)) for disparity and 2^ACC_W-1 for ones. Defaults never saturate (max |disp| = 128, max ones = 128).
- clear (priority below reset, above everything else):
  - Forces state IDLE and zeroes accumulators, counter, err and out_valid in any state, including REPORT, where the pending result is dropped.
  - A byte presented with clear is not accepted.
- in_valid while in_ready = 0 is ignored; the upstream must hold the byte.
- Reset mid-window or mid-REPORT: immediate return to reset values; the partial window is lost.
- No combinational path from in_* to out_*.

Test Plan:
- (WINDOW=4, THRESH=8 overrides for all tests.)
- Balanced window: counts 4,4,4,4 back-to-back, out_ready=1 -> one cycle after 4th byte out_valid=1, disparity 0, ones 16, imbalance 0, err 0; next cycle out_valid=0, in_ready=1.
- All ones: counts 8,8,8,8 -> disparity +32, ones 32, imbalance 1. Then counts 0,0,0,8 -> disparity -16, ones 8, imbalance 1.
- Backpressure: window 2,3,5,6 with out_ready=0 for 5 cycles and in_valid held high -> in_ready=0, outputs stable at disparity 0 / ones 16; byte counter unchanged; after out_ready=1 handshake, in_ready=1 the following cycle and a new window starts.
- Illegal count: counts 9,4,4,4 -> treated as 8: disparity +8, ones 20, err 1, imbalance 0. The next clean window reports err 0.
- Clear: accept 8,8 then pulse clear with in_valid=1, count 8 -> byte not taken; following counts 1,1,1,1 report disparity -24, ones 4.
- Async reset: assert reset between clock edges mid-ACCUM and in REPORT -> out_valid/out_* go 0 immediately; after release, a fresh 4,4,4,4 window reports disparity 0.

Source files
------------

// File: rtl/bit_balance_monitor.sv
// Purpose: accumulates running disparity (ones minus zeros) and total ones of per-byte popcounts over a fixed window.
// Latency: window result is registered and visible one cycle after the final accepted byte of the window.
// Backpressure: in_ready drops while a result is held; result stays stable until out_valid & out_ready.
module bit_balance_monitor #(
    parameter int          WINDOW = 16,
    parameter int          ACC_W  = 10,
    parameter int unsigned THRESH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_count,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_disparity,
    output logic [ACC_W-1:0] out_ones,
    output logic             out_imbalance,
    output logic             out_err
);

    localparam int               CNT_W    = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   disp_q, disp_d;
    logic [ACC_W-1:0]   ones_q, ones_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_disp_q, out_disp_d;
    logic [ACC_W-1:0]   out_ones_q, out_ones_d;
    logic               out_imb_q, out_imb_d;
    logic               out_err_q, out_err_d;

    // Datapath for one incoming byte: clamp, signed term, saturating sums.
    logic                illegal;
    logic [3:0]          c_clamp;
    logic signed [5:0]   term;
    logic signed [ACC_W:0] disp_sum;
    logic [ACC_W:0]      ones_sum;
    logic [ACC_W-1:0]    disp_new;
    logic [ACC_W-1:0]    ones_new;
    logic [ACC_W:0]      disp_mag;
    logic                imb_new;
    logic [CNT_W-1:0]    cnt_inc;
    logic                last_byte;

    // Compute the would-be accumulator values if the current byte is accepted.
    always_comb begin
        illegal  = (in_count > 4'd8);
        c_clamp  = illegal ? 4'd8 : in_count;
        // 2*c - 8 lies in [-8, +8], so six signed bits are enough.
        term     = $signed({1'b0, c_clamp, 1'b0}) - 6'sd8;
        disp_sum = $signed({disp_q[ACC_W-1], disp_q}) + (ACC_W+1)'(term);
        // Overflow shows up as disagreement between the two top bits.
        if (disp_sum[ACC_W] != disp_sum[ACC_W-1]) begin
            disp_new = disp_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            disp_new = disp_sum[ACC_W-1:0];
        end
        ones_sum = {1'b0, ones_q} + (ACC_W+1)'(c_clamp);
        ones_new = ones_sum[ACC_W] ? {ACC_W{1'b1}} : ones_sum[ACC_W-1:0];
        // One extra bit so the most negative disparity has a representable magnitude.
        disp_mag = {disp_new[ACC_W-1], disp_new};
        if (disp_new[ACC_W-1]) begin
            disp_mag = ~disp_mag + (ACC_W+1)'(1);
        end
        imb_new   = (32'(disp_mag) > THRESH);
        cnt_inc   = cnt_q + CNT_W'(1);
        last_byte = (cnt_inc == LAST_CNT);
    end

    // Input side is open whenever no result is waiting for the consumer.
    always_comb begin
        in_ready = (state_q != REPORT);
    end

    // Next-state and next-register logic; clear overrides all normal traffic.
    always_comb begin
        state_d     = state_q;
        disp_d      = disp_q;
        ones_d      = ones_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_disp_d  = out_disp_q;
        out_ones_d  = out_ones_q;
        out_imb_d   = out_imb_q;
        out_err_d   = out_err_q;

        if (clear) begin
            // Aborts the window and drops any pending result; the byte on the bus is not taken.
            state_d     = IDLE;
            disp_d      = '0;
            ones_d      = '0;
            cnt_d       = '0;
            err_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        disp_d = disp_new;
                        ones_d = ones_new;
                        cnt_d  = cnt_inc;
                        err_d  = err_q | illegal;
                        if (last_byte) begin
                            // Window closes on this edge, totals include the closing byte.
                            state_d     = REPORT;
                            out_valid_d = 1'b1;
                            out_disp_d  = disp_new;
                            out_ones_d  = ones_new;
                            out_imb_d   = imb_new;
                            out_err_d   = err_q | illegal;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        // Handshake retires the result; input reopens next cycle.
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        disp_d      = '0;
                        ones_d      = '0;
                        cnt_d       = '0;
                        err_d       = 1'b0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    disp_d      = '0;
                    ones_d      = '0;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                end
            endcase
        end
    end

    // State and result registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            disp_q      <= '0;
            ones_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_disp_q  <= '0;
            out_ones_q  <= '0;
            out_imb_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            disp_q      <= disp_d;
            ones_q      <= ones_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_disp_q  <= out_disp_d;
            out_ones_q  <= out_ones_d;
            out_imb_q   <= out_imb_d;
            out_err_q   <= out_err_d;
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        out_valid     = out_valid_q;
        out_disparity = out_disp_q;
        out_ones      = out_ones_q;
        out_imbalance = out_imb_q;
        out_err       = out_err_q;
    end

endmodule
